// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - two-port round-robin issue controller sharing one FPU core
// Tags each issued op through a latency-matched delay line and routes results back.
module fpu_arbiter #(
  parameter int FPU_LAT = 4,
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_opa,
  input  logic [31:0] req0_opb,
  input  logic [2:0]  req0_op,
  input  logic [1:0]  req0_rmode,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_opa,
  input  logic [31:0] req1_opb,
  input  logic [2:0]  req1_op,
  input  logic [1:0]  req1_rmode,

  output logic [31:0] fpu_opa,
  output logic [31:0] fpu_opb,
  output logic [2:0]  fpu_op,
  output logic [1:0]  fpu_rmode,
  input  logic [31:0] fpu_out,
  input  logic [7:0]  fpu_flags,

  output logic        resp0_valid,
  output logic [31:0] resp0_result,
  output logic [7:0]  resp0_flags,

  output logic        resp1_valid,
  output logic [31:0] resp1_result,
  output logic [7:0]  resp1_flags
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0]  cnt0;
  logic [CW-1:0]  cnt1;
  logic           last;
  logic [FPU_LAT:0] dl_valid;
  logic [FPU_LAT:0] dl_tag;

  logic elig0;
  logic elig1;
  logic take0;
  logic take1;
  logic tail_valid;
  logic tail_tag;

  // A response strobe this cycle frees a credit, so it counts toward eligibility now.
  assign elig0 = req0_valid && ((cnt0 < CNT_MAX) || resp0_valid);
  assign elig1 = req1_valid && ((cnt1 < CNT_MAX) || resp1_valid);

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst) begin
      req0_ready = elig0 && (!elig1 || last);
      req1_ready = elig1 && (!elig0 || !last);
    end
  end

  assign take0      = req0_valid && req0_ready;
  assign take1      = req1_valid && req1_ready;
  assign tail_valid = dl_valid[FPU_LAT];
  assign tail_tag   = dl_tag[FPU_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_opa   <= 32'd0;
      fpu_opb   <= 32'd0;
      fpu_op    <= 3'd0;
      fpu_rmode <= 2'd0;
      last      <= 1'b1;
    end else if (take0) begin
      fpu_opa   <= req0_opa;
      fpu_opb   <= req0_opb;
      fpu_op    <= req0_op;
      fpu_rmode <= req0_rmode;
      last      <= 1'b0;
    end else if (take1) begin
      fpu_opa   <= req1_opa;
      fpu_opb   <= req1_opb;
      fpu_op    <= req1_op;
      fpu_rmode <= req1_rmode;
      last      <= 1'b1;
    end
  end

  // Stage k holds the op whose registered FPU inputs were presented k cycles ago.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_valid <= '0;
      dl_tag   <= '0;
    end else begin
      dl_valid <= {dl_valid[FPU_LAT-1:0], take0 | take1};
      dl_tag   <= {dl_tag[FPU_LAT-1:0], take1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp0_valid  <= 1'b0;
      resp0_result <= 32'd0;
      resp0_flags  <= 8'd0;
      resp1_valid  <= 1'b0;
      resp1_result <= 32'd0;
      resp1_flags  <= 8'd0;
    end else begin
      resp0_valid <= tail_valid && !tail_tag;
      resp1_valid <= tail_valid && tail_tag;
      if (tail_valid && !tail_tag) begin
        resp0_result <= fpu_out;
        resp0_flags  <= fpu_flags;
      end
      if (tail_valid && tail_tag) begin
        resp1_result <= fpu_out;
        resp1_flags  <= fpu_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      case ({take0, resp0_valid})
        2'b10:   cnt0 <= cnt0 + CNT_ONE;
        2'b01:   cnt0 <= cnt0 - CNT_ONE;
        default: cnt0 <= cnt0;
      endcase
      case ({take1, resp1_valid})
        2'b10:   cnt1 <= cnt1 + CNT_ONE;
        2'b01:   cnt1 <= cnt1 - CNT_ONE;
        default: cnt1 <= cnt1;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - directed self-checking bench for fpu_arbiter
// Includes a table-driven FPU stand-in with the same latency as the real core.
module tb_fpu_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_opa, req0_opb, req1_opa, req1_opb;
  logic [2:0]  req0_op, req1_op;
  logic [1:0]  req0_rmode, req1_rmode;
  logic [31:0] fpu_opa, fpu_opb, fpu_out;
  logic [2:0]  fpu_op;
  logic [1:0]  fpu_rmode;
  logic [7:0]  fpu_flags;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp0_result, resp1_result;
  logic [7:0]  resp0_flags, resp1_flags;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fpu_arbiter #(.FPU_LAT(LAT), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opa(req0_opa),
    .req0_opb(req0_opb), .req0_op(req0_op), .req0_rmode(req0_rmode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opa(req1_opa),
    .req1_opb(req1_opb), .req1_op(req1_op), .req1_rmode(req1_rmode),
    .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .fpu_op(fpu_op), .fpu_rmode(fpu_rmode),
    .fpu_out(fpu_out), .fpu_flags(fpu_flags),
    .resp0_valid(resp0_valid), .resp0_result(resp0_result), .resp0_flags(resp0_flags),
    .resp1_valid(resp1_valid), .resp1_result(resp1_result), .resp1_flags(resp1_flags)
  );

  // Known IEEE cases from the vectors; anything else gets an easily predicted pattern.
  function automatic logic [39:0] fpu_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
    if (op == 3'd0 && a == 32'h3F800000 && b == 32'h3F800000) return {8'h00, 32'h40000000};
    if (op == 3'd3 && a == 32'h3F800000 && b == 32'h00000000) return {8'h81, 32'h7F800000};
    if (op == 3'd2 && a == 32'h00000000 && b == 32'h7F800000) return {8'h20, 32'h7FC00000};
    return {a[7:0], a ^ b ^ {29'd0, op}};
  endfunction

  logic [39:0] pipe [0:LAT-1];
  always_ff @(posedge clk) begin
    pipe[0] <= fpu_calc(fpu_opa, fpu_opb, fpu_op);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign fpu_out   = pipe[LAT-1][31:0];
  assign fpu_flags = pipe[LAT-1][39:32];

  task automatic idle_inputs;
    req0_valid = 0; req0_opa = 0; req0_opb = 0; req0_op = 0; req0_rmode = 0;
    req1_valid = 0; req1_opa = 0; req1_opb = 0; req1_op = 0; req1_rmode = 0;
  endtask

  // Leaves the bench at the start of cycle 0, the first cycle with rst low.
  task automatic do_reset;
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1;
    @(posedge clk);
    #1;
    req0_valid = 1; req1_valid = 1; req0_opa = 32'h12345678; req1_opa = 32'h9ABCDEF0;
    @(negedge clk);
    n_tests++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++;
      $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
    n_tests++; if ({fpu_opa, fpu_opb, fpu_op, fpu_rmode} !== 69'd0) begin n_fail++;
      $display("FAIL reset_fpu_in: got %h/%h/%h/%h expected 0", fpu_opa, fpu_opb, fpu_op, fpu_rmode); end
    n_tests++; if ({resp0_valid, resp1_valid, resp0_result, resp1_result, resp0_flags, resp1_flags} !== 82'd0) begin
      n_fail++; $display("FAIL reset_resp: got %b%b %h %h expected 0", resp0_valid, resp1_valid, resp0_result, resp1_result); end
    n_tests++; if (dut.cnt0 !== 2'd0 || dut.cnt1 !== 2'd0) begin n_fail++;
      $display("FAIL reset_cnt: got %0d/%0d expected 0/0", dut.cnt0, dut.cnt1); end
    idle_inputs();
  endtask

  task automatic test_single_add;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      idle_inputs();
      if (c == 0) begin req0_valid = 1; req0_opa = 32'h3F800000; req0_opb = 32'h3F800000; end
      @(negedge clk);
      if (c == 0) begin n_tests++; if (req0_ready !== 1'b1) begin n_fail++;
        $display("FAIL add_ready: got %b expected 1", req0_ready); end end
      if (c == 1) begin n_tests++; if (fpu_opa !== 32'h3F800000 || fpu_op !== 3'd0) begin n_fail++;
        $display("FAIL add_fpu_in: got %h op %h expected 3f800000 op 0", fpu_opa, fpu_op); end end
      n_tests++; if (resp0_valid !== (c == 6) || resp1_valid !== 1'b0) begin n_fail++;
        $display("FAIL add_strobe c%0d: got %b%b expected %b0", c, resp0_valid, resp1_valid, c == 6); end
      if (c == 6) begin n_tests++; if (resp0_result !== 32'h40000000 || resp0_flags !== 8'h00) begin n_fail++;
        $display("FAIL add_result: got %h/%h expected 40000000/00", resp0_result, resp0_flags); end end
      next_cycle();
    end
  endtask

  task automatic test_contention;
    int gp [0:15];
    do_reset();
    for (int c = 0; c < 16; c++) begin
      int m;
      m = c % 6;
      gp[c] = (m == 0 || m == 2) ? 0 : (m == 1 || m == 3) ? 1 : 2;
      req0_valid = 1; req0_opa = 32'h1000 + c; req0_opb = 32'h00FF0000; req0_op = 0; req0_rmode = 0;
      req1_valid = 1; req1_opa = 32'h2000 + c; req1_opb = 32'h0000FF00; req1_op = 0; req1_rmode = 1;
      @(negedge clk);
      n_tests++; if (req0_ready !== (gp[c] == 0) || req1_ready !== (gp[c] == 1)) begin n_fail++;
        $display("FAIL cont_grant c%0d: got %b%b expected grant %0d", c, req0_ready, req1_ready, gp[c]); end
      if (c >= 6) begin
        int g;
        g = gp[c-6];
        n_tests++; if (resp0_valid !== (g == 0) || resp1_valid !== (g == 1)) begin n_fail++;
          $display("FAIL cont_resp c%0d: got %b%b expected port %0d", c, resp0_valid, resp1_valid, g); end
        if (g == 0) begin n_tests++; if (resp0_result !== ((32'h1000 + c - 6) ^ 32'h00FF0000)) begin n_fail++;
          $display("FAIL cont_res0 c%0d: got %h expected %h", c, resp0_result, (32'h1000 + c - 6) ^ 32'h00FF0000); end end
        if (g == 1) begin n_tests++; if (resp1_result !== ((32'h2000 + c - 6) ^ 32'h0000FF00)) begin n_fail++;
          $display("FAIL cont_res1 c%0d: got %h expected %h", c, resp1_result, (32'h2000 + c - 6) ^ 32'h0000FF00); end end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_credits;
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      logic exp_rdy;
      logic [1:0] exp_cnt;
      exp_rdy = (c <= 1) || (c >= 6);
      exp_cnt = (c == 0) ? 2'd0 : (c == 1) ? 2'd1 : 2'd2;
      req0_valid = 1; req0_opa = 32'h4000 + c; req0_opb = 32'h1;
      @(negedge clk);
      n_tests++; if (req0_ready !== exp_rdy) begin n_fail++;
        $display("FAIL credit_ready c%0d: got %b expected %b", c, req0_ready, exp_rdy); end
      n_tests++; if (dut.cnt0 !== exp_cnt) begin n_fail++;
        $display("FAIL credit_cnt c%0d: got %0d expected %0d", c, dut.cnt0, exp_cnt); end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_div_zero;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      idle_inputs();
      if (c == 0) begin req1_valid = 1; req1_op = 3'd3; req1_opa = 32'h3F800000; req1_opb = 32'h0; end
      @(negedge clk);
      if (c == 6) begin
        n_tests++; if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0) begin n_fail++;
          $display("FAIL div_strobe: got %b%b expected 01", resp0_valid, resp1_valid); end
        n_tests++; if (resp1_flags[0] !== 1'b1 || resp1_flags[7] !== 1'b1 || resp1_result !== 32'h7F800000) begin n_fail++;
          $display("FAIL div_result: got %h/%h expected 7f800000 with flags bits 7,0", resp1_result, resp1_flags); end
        n_tests++; if (resp0_result !== 32'd0 || resp0_flags !== 8'd0) begin n_fail++;
          $display("FAIL div_other_hold: got %h/%h expected 0/0", resp0_result, resp0_flags); end
      end
      next_cycle();
    end
  endtask

  task automatic test_nan;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      idle_inputs();
      if (c == 0) begin req0_valid = 1; req0_op = 3'd2; req0_opa = 32'h0; req0_opb = 32'h7F800000; end
      @(negedge clk);
      if (c == 6) begin
        n_tests++; if (resp0_valid !== 1'b1 || resp0_flags[5] !== 1'b1 || resp0_result !== 32'h7FC00000) begin n_fail++;
          $display("FAIL nan_result: got v%b %h/%h expected v1 7fc00000 qnan", resp0_valid, resp0_result, resp0_flags); end
      end
      next_cycle();
    end
  endtask

  task automatic test_passthrough;
    do_reset();
    for (int c = 0; c <= 2; c++) begin
      idle_inputs();
      if (c == 0) begin req1_valid = 1; req1_op = 3'd6; req1_rmode = 2'd3; req1_opa = 32'hA5A5A5A5; req1_opb = 32'h5A5A5A5A; end
      @(negedge clk);
      if (c >= 1) begin n_tests++;
        if (fpu_op !== 3'd6 || fpu_rmode !== 2'd3 || fpu_opa !== 32'hA5A5A5A5 || fpu_opb !== 32'h5A5A5A5A) begin n_fail++;
          $display("FAIL passthru c%0d: got %h %h %h %h expected 6 3 a5a5a5a5 5a5a5a5a", c, fpu_op, fpu_rmode, fpu_opa, fpu_opb); end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      idle_inputs();
      rst = (c == 3);
      if (c <= 1) begin req0_valid = 1; req0_opa = 32'h3F800000; req0_opb = 32'h3F800000; end
      if (c == 4) begin req0_valid = 1; req1_valid = 1; end
      @(negedge clk);
      if (c <= 1) begin n_tests++; if (req0_ready !== 1'b1) begin n_fail++;
        $display("FAIL mid_accept c%0d: got %b expected 1", c, req0_ready); end end
      if (c == 3) begin n_tests++; if (req0_ready !== 1'b0) begin n_fail++;
        $display("FAIL mid_rst_ready: got %b expected 0", req0_ready); end end
      if (c >= 3) begin n_tests++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin n_fail++;
        $display("FAIL mid_no_resp c%0d: got %b%b expected 00", c, resp0_valid, resp1_valid); end end
      if (c == 4) begin
        n_tests++; if (dut.cnt0 !== 2'd0) begin n_fail++;
          $display("FAIL mid_cnt0: got %0d expected 0", dut.cnt0); end
        n_tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++;
          $display("FAIL mid_tie: got %b%b expected 10", req0_ready, req1_ready); end
      end
      next_cycle();
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_add();
    test_contention();
    test_credits();
    test_div_zero();
    test_nan();
    test_passthrough();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
